// File: rtl/fetch_unit_pkg.sv
// Shared encodings for the fetch stage and the controller:
// next-PC select codes and fetch FSM states.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'b00,
        NPC_BRANCH = 2'b01,
        NPC_JUMP   = 2'b10,
        NPC_JREG   = 2'b11
    } npc_op_e;

    typedef enum logic [1:0] {
        S_IDLE  = 2'b00,
        S_FETCH = 2'b01,
        S_WAIT  = 2'b10,
        S_HOLD  = 2'b11
    } fetch_state_e;

    localparam logic [31:0] JREG_MASK = 32'hFFFF_FFFC;

endpackage

// File: rtl/fetch_unit_npc_calc.sv
// Combinational next-PC: pc+4, branch, jump, jump-register.
// Ports: pc, npc_op, imm16, jaddr26, rs_data in; pc_plus4, next_pc out.
module npc_calc
    import fetch_unit_pkg::*;
(
    input  logic [31:0] pc,
    input  npc_op_e     npc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr26,
    input  logic [31:0] rs_data,
    output logic [31:0] pc_plus4,
    output logic [31:0] next_pc
);

    logic [31:0] br_off;

    assign pc_plus4 = pc + 32'd4;
    assign br_off   = {{14{imm16[15]}}, imm16, 2'b00};

    always_comb begin
        next_pc = pc_plus4;
        unique case (npc_op)
            NPC_PLUS4:  next_pc = pc_plus4;
            NPC_BRANCH: next_pc = pc_plus4 + br_off;
            NPC_JUMP:   next_pc = {pc_plus4[31:28], jaddr26, 2'b00};
            NPC_JREG:   next_pc = rs_data & JREG_MASK;
            default:    next_pc = pc_plus4;
        endcase
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/gnt/rvalid fetch,
// holds inst until commit, then advances pc via npc_calc.
// Ports: clk, rstn, npc_op/imm16/jaddr26/rs_data/commit from control;
// imem_req/addr/gnt/rvalid/rdata to memory; inst/inst_valid/pc/pc_plus4 out.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic [1:0]  npc_op,
    input  logic [15:0] imm16,
    input  logic [25:0] jaddr26,
    input  logic [31:0] rs_data,
    input  logic        commit,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4
);

    fetch_state_e state_q, state_d;
    logic [31:0]  pc_q;
    logic [31:0]  inst_q;
    logic [31:0]  next_pc;
    logic         load_inst;
    logic         advance;

    npc_calc u_npc (
        .pc       (pc_q),
        .npc_op   (npc_op_e'(npc_op)),
        .imm16    (imm16),
        .jaddr26  (jaddr26),
        .rs_data  (rs_data),
        .pc_plus4 (pc_plus4),
        .next_pc  (next_pc)
    );

    // rvalid only counts in WAIT, commit only in HOLD; anything
    // arriving in other states is dropped.
    always_comb begin
        state_d   = state_q;
        load_inst = 1'b0;
        advance   = 1'b0;
        unique case (state_q)
            S_IDLE:  state_d = S_FETCH;
            S_FETCH: if (imem_gnt) state_d = S_WAIT;
            S_WAIT: begin
                if (imem_rvalid) begin
                    load_inst = 1'b1;
                    state_d   = S_HOLD;
                end
            end
            S_HOLD: begin
                if (commit) begin
                    advance = 1'b1;
                    state_d = S_FETCH;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            pc_q   <= RESET_PC;
            inst_q <= 32'h0;
        end else begin
            if (advance)   pc_q   <= next_pc;
            if (load_inst) inst_q <= imem_rdata;
        end
    end

    assign imem_req   = (state_q == S_FETCH);
    assign imem_addr  = pc_q;
    assign inst       = inst_q;
    assign inst_valid = (state_q == S_HOLD);
    assign pc         = pc_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: vector table of commits with
// expected next fetch addresses, plus handshake corner sequences.
module tb_fetch_unit;

    localparam logic [31:0] K = 32'hA5A5_0000;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic [1:0]  npc_op = 2'b00;
    logic [15:0] imm16 = 16'h0;
    logic [25:0] jaddr26 = 26'h0;
    logic [31:0] rs_data = 32'h0;
    logic        commit = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] inst;
    logic        inst_valid;
    logic [31:0] pc;
    logic [31:0] pc_plus4;

    int total = 0;
    int bad = 0;

    fetch_unit #(.RESET_PC(32'h0)) dut (
        .clk         (clk),
        .rstn        (rstn),
        .npc_op      (npc_op),
        .imm16       (imm16),
        .jaddr26     (jaddr26),
        .rs_data     (rs_data),
        .commit      (commit),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .inst        (inst),
        .inst_valid  (inst_valid),
        .pc          (pc),
        .pc_plus4    (pc_plus4)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  op;
        logic [15:0] imm;
        logic [25:0] jad;
        logic [31:0] rs;
        logic [31:0] exp_addr;
        int          gnt_delay;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Wait for a request, serve it, check the held instruction.
    task automatic serve(input logic [31:0] exp_addr, input int gnt_delay);
        int n = 0;
        while (imem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        chk("req_seen", {31'b0, imem_req}, 32'd1);
        chk("fetch_addr", imem_addr, exp_addr);
        for (int i = 0; i < gnt_delay; i++) begin
            step();
            chk("req_held", {31'b0, imem_req}, 32'd1);
            chk("addr_held", imem_addr, exp_addr);
        end
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        chk("wait_req_low", {31'b0, imem_req}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = exp_addr ^ K;
        step();
        imem_rvalid = 1'b0;
        imem_rdata  = 32'hDEAD_BEEF;
        chk("inst_valid", {31'b0, inst_valid}, 32'd1);
        chk("inst", inst, exp_addr ^ K);
        chk("pc", pc, exp_addr);
        chk("pc_plus4", pc_plus4, exp_addr + 32'd4);
    endtask

    task automatic do_commit(input logic [1:0] op, input logic [15:0] im,
                             input logic [25:0] ja, input logic [31:0] rs);
        npc_op  = op;
        imm16   = im;
        jaddr26 = ja;
        rs_data = rs;
        commit  = 1'b1;
        step();
        commit  = 1'b0;
        npc_op  = 2'b00;
        imm16   = 16'h0;
        jaddr26 = 26'h0;
        rs_data = 32'h0;
        chk("commit_valid_low", {31'b0, inst_valid}, 32'd0);
        chk("commit_next_req", {31'b0, imem_req}, 32'd1);
    endtask

    initial begin
        vecs[0]  = '{2'b00, 16'h7777, 26'h3FFFFFF, 32'h1111_1111, 32'h0000_0004, 0};
        vecs[1]  = '{2'b00, 16'h8000, 26'h0000001, 32'h2222_2222, 32'h0000_0008, 0};
        vecs[2]  = '{2'b00, 16'h0001, 26'h1234567, 32'h3333_3333, 32'h0000_000C, 4};
        vecs[3]  = '{2'b11, 16'h0004, 26'h0000040, 32'h0000_0103, 32'h0000_0100, 0};
        vecs[4]  = '{2'b01, 16'hFFFE, 26'h0000040, 32'h0000_0200, 32'h0000_00FC, 1};
        vecs[5]  = '{2'b11, 16'h0010, 26'h0000080, 32'h0000_0100, 32'h0000_0100, 0};
        vecs[6]  = '{2'b01, 16'h0003, 26'h0000020, 32'h0000_0800, 32'h0000_0110, 0};
        vecs[7]  = '{2'b11, 16'h0040, 26'h0000999, 32'h3000_0043, 32'h3000_0040, 0};
        vecs[8]  = '{2'b10, 16'h0040, 26'h0000100, 32'h0000_5000, 32'h3000_0400, 2};
        vecs[9]  = '{2'b11, 16'h0002, 26'h0000010, 32'h0000_1237, 32'h0000_1234, 0};
        vecs[10] = '{2'b11, 16'h0002, 26'h0000010, 32'hFFFF_FFFF, 32'hFFFF_FFFC, 0};
        vecs[11] = '{2'b00, 16'h0005, 26'h0000011, 32'h0000_0040, 32'h0000_0000, 0};

        // Reset state, then first fetch with gnt tied high.
        #2;
        chk("rst_req", {31'b0, imem_req}, 32'd0);
        chk("rst_valid", {31'b0, inst_valid}, 32'd0);
        chk("rst_pc", pc, 32'h0);
        chk("rst_inst", inst, 32'h0);
        step();
        step();
        rstn = 1'b1;
        imem_gnt = 1'b1;
        step();
        chk("t1_req", {31'b0, imem_req}, 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        chk("t1_valid_c1", {31'b0, inst_valid}, 32'd0);
        step();
        imem_gnt = 1'b0;
        chk("t1_req_c2", {31'b0, imem_req}, 32'd0);
        chk("t1_valid_c2", {31'b0, inst_valid}, 32'd0);
        imem_rvalid = 1'b1;
        imem_rdata  = K;
        step();
        imem_rvalid = 1'b0;
        chk("t1_valid_c3", {31'b0, inst_valid}, 32'd1);
        chk("t1_inst", inst, K);
        chk("t1_pc", pc, 32'h0);
        chk("t1_pc4", pc_plus4, 32'h4);

        // Stray rvalid in HOLD leaves inst untouched.
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h1234_5678;
        step();
        imem_rvalid = 1'b0;
        chk("stray_inst", inst, K);
        chk("stray_valid", {31'b0, inst_valid}, 32'd1);
        chk("stray_req", {31'b0, imem_req}, 32'd0);

        for (int i = 0; i < 12; i++) begin
            do_commit(vecs[i].op, vecs[i].imm, vecs[i].jad, vecs[i].rs);
            serve(vecs[i].exp_addr, vecs[i].gnt_delay);
        end

        // pc = 0. gnt+rvalid together in FETCH: only gnt counts;
        // commit alone in WAIT dropped; commit+rvalid in WAIT: rvalid wins.
        do_commit(2'b00, 16'h0, 26'h0, 32'h0);
        chk("c_addr", imem_addr, 32'h4);
        imem_gnt    = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0001;
        step();
        imem_gnt    = 1'b0;
        imem_rvalid = 1'b0;
        chk("c_gnt_rv_valid", {31'b0, inst_valid}, 32'd0);
        chk("c_gnt_rv_req", {31'b0, imem_req}, 32'd0);
        commit = 1'b1;
        npc_op = 2'b11;
        rs_data = 32'h0000_0800;
        step();
        chk("c_wait_commit_valid", {31'b0, inst_valid}, 32'd0);
        chk("c_wait_commit_pc", pc, 32'h4);
        imem_rvalid = 1'b1;
        imem_rdata  = 32'h0000_C0DE;
        step();
        imem_rvalid = 1'b0;
        commit = 1'b0;
        npc_op = 2'b00;
        rs_data = 32'h0;
        chk("c_rv_commit_valid", {31'b0, inst_valid}, 32'd1);
        chk("c_rv_commit_inst", inst, 32'h0000_C0DE);
        chk("c_rv_commit_pc", pc, 32'h4);
        step();
        chk("c_hold_inst", inst, 32'h0000_C0DE);
        chk("c_hold_pc4", pc_plus4, 32'h8);

        // Reset during WAIT; stale rvalid right after release.
        do_commit(2'b00, 16'h0, 26'h0, 32'h0);
        chk("r_addr", imem_addr, 32'h8);
        imem_gnt = 1'b1;
        step();
        imem_gnt = 1'b0;
        #2 rstn = 1'b0;
        #1;
        chk("r_pc", pc, 32'h0);
        chk("r_inst", inst, 32'h0);
        chk("r_req", {31'b0, imem_req}, 32'd0);
        chk("r_valid", {31'b0, inst_valid}, 32'd0);
        step();
        rstn = 1'b1;
        imem_rvalid = 1'b1;
        imem_rdata  = 32'hBAD0_0002;
        step();
        imem_rvalid = 1'b0;
        chk("r_stale_valid", {31'b0, inst_valid}, 32'd0);
        chk("r_stale_inst", inst, 32'h0);
        chk("r_refetch_req", {31'b0, imem_req}, 32'd1);
        serve(32'h0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

endmodule
